piso_tx: RTL
============

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame (legal range 1..32).
REQ-002 SHALL have parameter BIT_CYCLES, default 4, clock cycles each serial bit is held (legal range 1..256).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port data_in  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port load_valid  input  1  producer offers data_in this cycle.
REQ-007 SHALL have port load_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port sout  output  1  serial line; idles high.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress (START, DATA, STOP).
REQ-010 SHALL have port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 SHALL assert load_ready only in IDLE, as a registered-state decode with no combinational path from load_valid.
REQ-013 SHALL accept a word on a rising edge where load_valid and load_ready are both 1, capture data_in into a WIDTH-bit shift register and enter START.
REQ-014 SHALL ignore load_valid and data_in in any state other than IDLE, leaving the frame in progress unaffected.
REQ-015 SHALL drive sout from a register: 1 in IDLE, 0 in START, the shift register LSB in DATA, and 1 in STOP.
REQ-016 SHALL hold each state's bit for exactly BIT_CYCLES cycles using a bit-period counter that reloads on every bit boundary.
REQ-017 SHALL send data LSB first, shifting right once per bit boundary in DATA, with a bit index counter running 0..WIDTH-1.
REQ-018 SHALL go from DATA to STOP after bit WIDTH-1 completes, and from STOP to IDLE after BIT_CYCLES cycles.
REQ-019 SHALL make one frame exactly (WIDTH+2)*BIT_CYCLES cycles from the first START cycle to the last STOP cycle.
REQ-020 SHALL raise done for exactly one cycle, the first IDLE cycle after STOP, and SHALL assert load_ready in that same cycle.
REQ-021 SHALL accept the next word at the earliest on the edge that ends the done cycle, giving a minimum inter-frame gap of one idle-high cycle.
REQ-022 SHALL behave correctly at BIT_CYCLES=1, with one cycle per bit and no counter wrap errors.
REQ-023 SHALL size the counters as $clog2 of their ranges, with a minimum width of 1.

Reset
REQ-024 SHALL, while rst is high, immediately force state=IDLE, sout=1, busy=0, done=0, load_ready=1, and all counters and the shift register to 0.
REQ-025 SHALL let rst asserted mid-frame abort the frame at once, without emitting a done pulse for the aborted frame.
REQ-026 SHALL permit an accept on the first rising edge after rst deasserts.

Structure
REQ-027 SHALL place the state encoding (2-bit, IDLE=0, START=1, DATA=2, STOP=3) as named constants in a shared package piso_pkg.
REQ-028 SHALL place the bit-period counter in a sub-module bit_timer, with outputs tick on the final cycle of a period and input restart.
REQ-029 SHALL keep all other logic, including the shift register, index counter and FSM, in piso_tx.

Verification (WIDTH=8, BIT_CYCLES=4 unless stated)
REQ-030 SHALL cover: load 0xA5 -> sout = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy high for 40 cycles; one done pulse.
REQ-031 SHALL cover: load_valid held high continuously with 0x00 then 0xFF -> two frames separated by exactly one sout=1 cycle; the second frame carries 0xFF.
REQ-032 SHALL cover: load_valid pulsed with 0x3C during DATA of a frame carrying 0x81 -> 0x81 sent intact; 0x3C is never sent.
REQ-033 SHALL cover: rst asserted at cycle 15 of a frame -> sout=1, busy=0 and load_ready=1 without waiting for a clock edge; no done pulse.
REQ-034 SHALL cover: BIT_CYCLES=1, load 0x01 -> sout = 0,1,0,0,0,0,0,0,0,1 on consecutive cycles; done follows 10 cycles after the first START cycle.
REQ-035 SHALL cover: WIDTH=1, load 1 -> a frame of 3 bit periods (0,1,1), 12 cycles long.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// Holds the FSM state encoding used by piso_tx.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter for the serial transmitter.
// Pulses tick on the last cycle of each BIT_CYCLES-long period.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Reloading on tick keeps every period exactly BIT_CYCLES long, including BIT_CYCLES=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Each bit is held BIT_CYCLES cycles; done pulses on the first idle cycle after a frame.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] bit_idx_next;
  logic             tick;
  logic             restart;
  logic             accept;
  logic             sout_next;
  logic             done_next;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  assign accept = load_valid && load_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = START;
      START:   if (tick) next_state = DATA;
      DATA:    if (tick && (bit_idx == LAST_IDX)) next_state = STOP;
      STOP:    if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // load_ready is a pure state decode so load_valid never reaches it combinationally.
  always_comb begin
    load_ready = (state == IDLE);
    busy       = (state != IDLE);
    restart    = (state == IDLE);
    done_next  = (state == STOP) && tick;
    case (next_state)
      START:   sout_next = 1'b0;
      DATA:    sout_next = shreg_next[0];
      default: sout_next = 1'b1;
    endcase
  end

  always_comb begin
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    case (state)
      IDLE: begin
        bit_idx_next = '0;
        if (accept) shreg_next = data_in;
      end
      DATA: begin
        if (tick) begin
          shreg_next   = shreg >> 1;
          bit_idx_next = (bit_idx == LAST_IDX) ? '0 : bit_idx + IDX_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // sout and done are registered from next-cycle values so they change cleanly with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_idx <= '0;
      sout    <= 1'b1;
      done    <= 1'b0;
    end else begin
      shreg   <= shreg_next;
      bit_idx <= bit_idx_next;
      sout    <= sout_next;
      done    <= done_next;
    end
  end

endmodule
